// File: rtl/wb_sram_slave.sv
// wb_sram_slave: Wishbone slave with word-organised SRAM, bursts, wait states.
// Range-error reporting is built only when WB_SLAVE_ERR_EN is defined.
module wb_sram_slave #(
  parameter int          MEM_WORDS   = 16384,
  parameter int          WAIT_CYCLES = 0,
  parameter logic [31:0] BASE_ADDR   = 32'h0
) (
  input  logic        clk_i,
  input  logic        rst_n,
  input  logic [31:0] wbd_dat_i,
  input  logic [31:0] wbd_adr_i,
  input  logic [3:0]  wbd_sel_i,
  input  logic [9:0]  wbd_bl_i,
  input  logic        wbd_bry_i,
  input  logic        wbd_we_i,
  input  logic        wbd_cyc_i,
  input  logic        wbd_stb_i,
  output logic [31:0] wbd_dat_o,
  output logic        wbd_ack_o,
  output logic        wbd_lack_o,
  output logic        wbd_err_o
);

  localparam int AW        = $clog2(MEM_WORDS);
  localparam int MEM_BYTES = 4 * MEM_WORDS;

  localparam logic [3:0] WAIT_M1 =
    (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_WAIT = 3'd1;
  localparam logic [2:0] ST_DATA = 3'd2;
  localparam logic [2:0] ST_DONE = 3'd3;
`ifdef WB_SLAVE_ERR_EN
  localparam logic [2:0] ST_ERR  = 3'd4;
`endif

  logic [2:0]    state_q, state_d;
  logic [AW-1:0] idx_q, idx_d;
  logic [9:0]    beats_q, beats_d;
  logic [3:0]    wait_q, wait_d;
  logic          we_q, we_d;
  logic          ack_q, ack_d;
  logic          lack_q, lack_d;
  logic [31:0]   dat_q;

  logic [31:0]   mem_q [MEM_WORDS];

  logic [31:0]   off;
  logic [9:0]    bl_eff;
  logic          req;
  logic          beat;
  logic          last;
  logic          wr_en;
  logic          rd_en;
  logic          unused_bits;

  // Offset from the window base; the word index is taken modulo MEM_WORDS.
  assign off    = wbd_adr_i - BASE_ADDR;
  assign bl_eff = (wbd_bl_i == 10'd0) ? 10'd1 : wbd_bl_i;
  assign req    = wbd_cyc_i & wbd_stb_i;
  assign beat   = (state_q == ST_DATA) & req & wbd_bry_i;
  assign last   = (beats_q <= 10'd1);

  // A reset edge must never commit a pending beat to memory.
  assign wr_en  = beat & we_q & rst_n;
  assign rd_en  = beat & ~we_q & rst_n;

  assign unused_bits = ^{off[1:0], off[31:AW+2]};

`ifdef WB_SLAVE_ERR_EN
  logic        err_q, err_d;
  logic        range_bad;
  logic [32:0] span_end;

  assign span_end  = {3'b000, off[31:2]} + {23'b0, bl_eff};
  assign range_bad = (off >= 32'(MEM_BYTES)) |
                     (span_end > 33'(MEM_WORDS));
  assign wbd_err_o = err_q;
`else
  assign wbd_err_o = 1'b0;
`endif

  assign wbd_dat_o  = dat_q;
  assign wbd_ack_o  = ack_q;
  assign wbd_lack_o = lack_q;

  // Next-state and pulse generation for the request/beat sequencer.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    beats_d = beats_q;
    wait_d  = wait_q;
    we_d    = we_q;
    ack_d   = 1'b0;
    lack_d  = 1'b0;
`ifdef WB_SLAVE_ERR_EN
    err_d   = 1'b0;
`endif
    unique case (state_q)
      ST_IDLE: begin
        if (req) begin
          idx_d   = off[AW+1:2];
          beats_d = bl_eff;
          we_d    = wbd_we_i;
          wait_d  = WAIT_M1;
          if (WAIT_CYCLES > 0) state_d = ST_WAIT;
          else                 state_d = ST_DATA;
`ifdef WB_SLAVE_ERR_EN
          if (range_bad) state_d = ST_ERR;
`endif
        end
      end
      ST_WAIT: begin
        if (!wbd_cyc_i) begin
          state_d = ST_IDLE;
        end else if (wait_q == 4'd0) begin
          state_d = ST_DATA;
        end else begin
          wait_d = wait_q - 4'd1;
        end
      end
      ST_DATA: begin
        if (!wbd_cyc_i) begin
          state_d = ST_IDLE;
        end else if (beat) begin
          ack_d   = 1'b1;
          idx_d   = idx_q + AW'(1);
          beats_d = beats_q - 10'd1;
          if (last) begin
            lack_d  = 1'b1;
            state_d = ST_DONE;
          end
        end
      end
      ST_DONE: begin
        if (!wbd_stb_i) state_d = ST_IDLE;
      end
`ifdef WB_SLAVE_ERR_EN
      ST_ERR: begin
        err_d   = 1'b1;
        state_d = ST_DONE;
      end
`endif
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Control state, response pulses and registered read data.
  always_ff @(posedge clk_i) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      beats_q <= '0;
      wait_q  <= '0;
      we_q    <= 1'b0;
      ack_q   <= 1'b0;
      lack_q  <= 1'b0;
      dat_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      beats_q <= beats_d;
      wait_q  <= wait_d;
      we_q    <= we_d;
      ack_q   <= ack_d;
      lack_q  <= lack_d;
      if (rd_en) dat_q <= mem_q[idx_q];
    end
  end

`ifdef WB_SLAVE_ERR_EN
  // Error pulse register.
  always_ff @(posedge clk_i) begin
    if (!rst_n) err_q <= 1'b0;
    else        err_q <= err_d;
  end
`endif

  // Byte-lane write port; contents survive reset.
  always_ff @(posedge clk_i) begin
    if (wr_en) begin
      for (int b = 0; b < 4; b++) begin
        if (wbd_sel_i[b]) mem_q[idx_q][8*b +: 8] <= wbd_dat_i[8*b +: 8];
      end
    end
  end

endmodule

// File: tb/tb_wb_sram_slave.sv
// tb_wb_sram_slave: directed checks of wb_sram_slave.
// Two instances: no wait states, and three wait states with a based window.
module tb_wb_sram_slave;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] dat_i;
  logic [31:0] adr_i;
  logic [3:0]  sel_i;
  logic [9:0]  bl_i;
  logic        bry_i;
  logic        we_i;
  logic        cyc0, stb0, cyc3, stb3;
  logic [31:0] dat0, dat3;
  logic        ack0, lack0, err0;
  logic        ack3, lack3, err3;

  bit          use3;
  logic [31:0] m_dat;
  logic        m_ack, m_lack, m_err;

  logic [31:0] wbuf [16];
  logic [31:0] rbuf [16];

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  assign m_dat  = use3 ? dat3  : dat0;
  assign m_ack  = use3 ? ack3  : ack0;
  assign m_lack = use3 ? lack3 : lack0;
  assign m_err  = use3 ? err3  : err0;

  wb_sram_slave #(
    .MEM_WORDS(16384), .WAIT_CYCLES(0), .BASE_ADDR(32'h0)
  ) u_dut0 (
    .clk_i(clk), .rst_n(rst_n),
    .wbd_dat_i(dat_i), .wbd_adr_i(adr_i), .wbd_sel_i(sel_i),
    .wbd_bl_i(bl_i), .wbd_bry_i(bry_i), .wbd_we_i(we_i),
    .wbd_cyc_i(cyc0), .wbd_stb_i(stb0),
    .wbd_dat_o(dat0), .wbd_ack_o(ack0),
    .wbd_lack_o(lack0), .wbd_err_o(err0)
  );

  wb_sram_slave #(
    .MEM_WORDS(256), .WAIT_CYCLES(3), .BASE_ADDR(32'h1000)
  ) u_dut3 (
    .clk_i(clk), .rst_n(rst_n),
    .wbd_dat_i(dat_i), .wbd_adr_i(adr_i), .wbd_sel_i(sel_i),
    .wbd_bl_i(bl_i), .wbd_bry_i(bry_i), .wbd_we_i(we_i),
    .wbd_cyc_i(cyc3), .wbd_stb_i(stb3),
    .wbd_dat_o(dat3), .wbd_ack_o(ack3),
    .wbd_lack_o(lack3), .wbd_err_o(err3)
  );

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input bit u3, input logic v);
    if (u3) begin cyc3 = v; stb3 = v; end
    else    begin cyc0 = v; stb0 = v; end
  endtask

  task automatic burst(input bit u3, input logic we,
                       input logic [31:0] adr, input logic [9:0] bl,
                       input logic [3:0] sel, input int nbeat,
                       input int stall_at, input int stall_n,
                       input int lat, input string tag);
    int   k = 0, first = -1, lacks = 0, lpos = -1;
    int   stalled = 0, sacks = 0, errs = 0;
    logic b;
    use3 = u3; we_i = we; adr_i = adr; bl_i = bl; sel_i = sel;
    set_req(u3, 1'b1);
    for (int c = 1; c <= 60 && k < nbeat; c++) begin
      b = !(k == stall_at && stalled < stall_n);
      bry_i = b;
      dat_i = wbuf[k];
      tick();
      if (m_err) errs++;
      if (!b) begin
        stalled++;
        if (m_ack) sacks++;
      end
      if (m_ack) begin
        if (first < 0) first = c;
        if (m_lack) begin lacks++; lpos = k; end
        if (!we) rbuf[k] = m_dat;
        k++;
      end
    end
    set_req(u3, 1'b0);
    bry_i = 1'b0;
    tick();
    chk({tag, "_lat"},   first, lat);
    chk({tag, "_acks"},  k, nbeat);
    chk({tag, "_lacks"}, lacks, 1);
    chk({tag, "_lpos"},  lpos, nbeat - 1);
    chk({tag, "_stall"}, sacks, 0);
    chk({tag, "_err"},   errs, 0);
    chk({tag, "_tail"},  m_ack, 0);
  endtask

`ifdef WB_SLAVE_ERR_EN
  task automatic errx(input logic we, input logic [31:0] adr,
                      input logic [9:0] bl, input string tag);
    int errs = 0, epos = -1, acks = 0;
    use3 = 1'b0; we_i = we; adr_i = adr; bl_i = bl;
    sel_i = 4'hF; dat_i = 32'h0BAD0BAD; bry_i = 1'b1;
    set_req(1'b0, 1'b1);
    for (int c = 1; c <= 6; c++) begin
      tick();
      if (m_err) begin
        errs++;
        if (epos < 0) epos = c;
      end
      if (m_ack | m_lack) acks++;
    end
    set_req(1'b0, 1'b0);
    bry_i = 1'b0;
    tick();
    chk({tag, "_errs"}, errs, 1);
    chk({tag, "_epos"}, epos, 2);
    chk({tag, "_ack"},  acks, 0);
  endtask
`endif

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int k, acks;
    rst_n = 1'b0;
    cyc0 = 1'b0; stb0 = 1'b0; cyc3 = 1'b0; stb3 = 1'b0;
    dat_i = '0; adr_i = '0; sel_i = '0; bl_i = '0;
    bry_i = 1'b0; we_i = 1'b0; use3 = 1'b0;
    for (int i = 0; i < 16; i++) begin wbuf[i] = '0; rbuf[i] = '0; end

    tick();
    tick();
    chk("rst_ack",  ack0,  0);
    chk("rst_lack", lack0, 0);
    chk("rst_err",  err0,  0);
    chk("rst_dat",  dat0,  0);
    chk("rst_ack3", ack3,  0);
    rst_n = 1'b1;
    tick();

    // single write/read
    wbuf[0] = 32'hDEADBEEF;
    burst(0, 1, 32'h100, 10'd1, 4'hF, 1, -1, 0, 2, "sw");
    burst(0, 0, 32'h100, 10'd0, 4'hF, 1, -1, 0, 2, "sr");
    chk("sr_data", rbuf[0], 32'hDEADBEEF);

    // byte lanes; read with sel 0 still returns the full word
    wbuf[0] = 32'hAABBCCDD;
    burst(0, 1, 32'h104, 10'd1, 4'hF, 1, -1, 0, 2, "bw0");
    wbuf[0] = 32'h11223344;
    burst(0, 1, 32'h104, 10'd1, 4'b0101, 1, -1, 0, 2, "bw1");
    burst(0, 0, 32'h104, 10'd1, 4'h0, 1, -1, 0, 2, "br");
    chk("br_data", rbuf[0], 32'hAA22CC44);

    // 4-beat burst, read back with a 2-cycle stall on beat 2
    for (int i = 0; i < 4; i++) wbuf[i] = 32'(i + 1);
    burst(0, 1, 32'h200, 10'd4, 4'hF, 4, -1, 0, 2, "bu_w");
    for (int i = 0; i < 4; i++) wbuf[i] = 32'hFFFF_FFFF;
    burst(0, 0, 32'h200, 10'd4, 4'hF, 4, 1, 2, 2, "bu_r");
    chk("bu_d0", rbuf[0], 32'd1);
    chk("bu_d1", rbuf[1], 32'd2);
    chk("bu_d2", rbuf[2], 32'd3);
    chk("bu_d3", rbuf[3], 32'd4);

    // wrap at the top word / range errors
    wbuf[0] = 32'h77770002;
    burst(0, 1, 32'h0, 10'd1, 4'hF, 1, -1, 0, 2, "w0");
`ifdef WB_SLAVE_ERR_EN
    errx(1'b0, 32'h0000FFFC, 10'd2, "e_span");
    errx(1'b1, 32'h00010000, 10'd1, "e_oor");
    burst(0, 0, 32'h0, 10'd1, 4'hF, 1, -1, 0, 2, "e_chk");
    chk("e_mem", rbuf[0], 32'h77770002);
`else
    wbuf[0] = 32'h77770001;
    burst(0, 1, 32'hFFFC, 10'd1, 4'hF, 1, -1, 0, 2, "wt");
    burst(0, 0, 32'hFFFC, 10'd2, 4'hF, 2, -1, 0, 2, "wr");
    chk("wr_d0", rbuf[0], 32'h77770001);
    chk("wr_d1", rbuf[1], 32'h77770002);
`endif

    // reset in the middle of an 8-beat write burst
    wbuf[0] = 32'h5555AAAA;
    burst(0, 1, 32'h30C, 10'd1, 4'hF, 1, -1, 0, 2, "pre");
    for (int i = 0; i < 8; i++) wbuf[i] = 32'hA5A50000 + 32'(i);
    use3 = 1'b0; we_i = 1'b1; adr_i = 32'h300; bl_i = 10'd8;
    sel_i = 4'hF; bry_i = 1'b1;
    set_req(1'b0, 1'b1);
    k = 0;
    for (int c = 1; c <= 20 && k < 3; c++) begin
      dat_i = wbuf[k];
      tick();
      if (m_ack) k++;
    end
    chk("mr_acks", k, 3);
    dat_i = wbuf[3];
    rst_n = 1'b0;
    tick();
    chk("mr_ack",  ack0,  0);
    chk("mr_lack", lack0, 0);
    chk("mr_dat",  dat0,  0);
    set_req(1'b0, 1'b0);
    bry_i = 1'b0;
    rst_n = 1'b1;
    acks = 0;
    for (int c = 0; c < 3; c++) begin
      tick();
      if (ack0) acks++;
    end
    chk("mr_quiet", acks, 0);
    burst(0, 0, 32'h300, 10'd4, 4'hF, 4, -1, 0, 2, "mr_rd");
    chk("mr_d0", rbuf[0], 32'hA5A50000);
    chk("mr_d1", rbuf[1], 32'hA5A50001);
    chk("mr_d2", rbuf[2], 32'hA5A50002);
    chk("mr_d3", rbuf[3], 32'h5555AAAA);

    // three wait states
    wbuf[0] = 32'hCAFEF00D;
    burst(1, 1, 32'h1010, 10'd1, 4'hF, 1, -1, 0, 5, "ws_w");
    burst(1, 0, 32'h1010, 10'd1, 4'hF, 1, -1, 0, 5, "ws_r");
    chk("ws_data", rbuf[0], 32'hCAFEF00D);

    // abort during WAIT
    use3 = 1'b1; we_i = 1'b0; adr_i = 32'h1020; bl_i = 10'd1;
    bry_i = 1'b1;
    set_req(1'b1, 1'b1);
    tick();
    tick();
    set_req(1'b1, 1'b0);
    acks = 0;
    for (int c = 0; c < 6; c++) begin
      tick();
      if (ack3) acks++;
    end
    chk("ab_acks", acks, 0);
    burst(1, 0, 32'h1010, 10'd1, 4'hF, 1, -1, 0, 5, "ab_r");
    chk("ab_data", rbuf[0], 32'hCAFEF00D);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/wb_sram_slave.md
# wb_sram_slave

Wishbone slave responder with an internal word-organised SRAM, replacing the bench-level ack-generator-plus-memory pair on the slave side of `wb_interconnect`. Supports single and incrementing burst transfers (`bl`/`bry`/`lack`), byte-lane writes, programmable wait states and optional range-error reporting. Used as the main memory model behind the interconnect in core simulations and as a synthesizable on-chip RAM.

## Interface
- `MEM_WORDS`, 16384: memory depth in 32-bit words, power of two; `MEM_BYTES = 4*MEM_WORDS`.
- `WAIT_CYCLES`, 0: idle cycles inserted between request accept and first beat, 0..15.
- `BASE_ADDR`, 32'h0: byte address mapped to word 0.

Ports:
- `clk_i` in 1: single clock; all state changes on the rising edge.
- `rst_n` in 1: synchronous, active-low reset.
- `wbd_dat_i` in 32: write data.
- `wbd_adr_i` in 32: byte address; bits [1:0] ignored.
- `wbd_sel_i` in 4: write byte enables; bit n gates byte n.
- `wbd_bl_i` in 10: burst length in beats; 0 is treated as 1.
- `wbd_bry_i` in 1: master beat ready; write data valid, or read data accepted.
- `wbd_we_i` in 1: 1 = write, 0 = read.
- `wbd_cyc_i` in 1: bus cycle active.
- `wbd_stb_i` in 1: request strobe.
- `wbd_dat_o` out 32: read data, registered.
- `wbd_ack_o` out 1: beat acknowledge, registered.
- `wbd_lack_o` out 1: last-beat acknowledge; asserted with `wbd_ack_o` on the final beat only.
- `wbd_err_o` out 1: error pulse. Driven only when `WB_SLAVE_ERR_EN` is defined; otherwise tied 0.

## Operation
- States:
  - IDLE: waiting for a request.
  - WAIT: counting wait states.
  - DATA: transferring beats.
  - ERR: reporting an error.
  - DONE: waiting for the strobe to drop.
- Accept: in IDLE, `wbd_cyc_i & wbd_stb_i` at an edge does the following:
  - Latches word index `(wbd_adr_i - BASE_ADDR) >> 2`, beat count `max(bl,1)` and `we`.
  - Next state is WAIT if `WAIT_CYCLES > 0`, otherwise DATA.
- WAIT: holds for exactly `WAIT_CYCLES` edges, then moves to DATA.
- DATA beat: performed at each edge where `wbd_stb_i & wbd_bry_i` are both 1.
  - Write: byte lanes selected by `wbd_sel_i` are written from `wbd_dat_i`.
  - Read: `wbd_dat_o <= mem[idx]`.
  - `wbd_ack_o <= 1`, index increments by 1, beat count decrements by 1.
  - If `bry` is 0 the beat stalls; `ack` is 0 that cycle.
- Last beat: `wbd_lack_o <= 1` alongside `ack`, and the state moves to DONE.
- Reads ignore `wbd_sel_i` and always return the full word.
- Word index arithmetic is modulo `MEM_WORDS`, so bursts wrap from the top word to word 0.
- DONE: returns to IDLE at the first edge where `wbd_stb_i == 0`. This prevents a registered-ack master from retriggering.
- Abort: `wbd_cyc_i == 0` in WAIT or DATA sends the state to IDLE at that edge.
  - No further acks are issued.
  - Beats already written stay written.
- Outputs: `wbd_ack_o`, `wbd_lack_o` and `wbd_err_o` are single-cycle pulses, 0 in every cycle without a beat or error. `wbd_dat_o` holds its last value.

## Timing
- Reset (`rst_n == 0` at an edge) gives:
  - state IDLE;
  - `wbd_ack_o`, `wbd_lack_o`, `wbd_err_o` = 0;
  - `wbd_dat_o` = 0;
  - counters cleared.
- Reset takes effect mid-burst with no further acks. Memory contents are not cleared.
- First-beat latency: with `bry` held at 1, `ack` is high `2 + WAIT_CYCLES` cycles after the cycle in which `stb` is first sampled high.
- Throughput: one beat per cycle with `bry` high. A burst of N beats completes in `N + 1 + WAIT_CYCLES` cycles after accept.
- Read data is valid in the same cycle as its `ack`.
- Write data is sampled at the beat edge, not at the ack cycle.
- Back-to-back: a new request is accepted no earlier than 1 cycle after `stb` drops (DONE to IDLE, then accept).

## Configuration
- `WB_SLAVE_ERR_EN` defined:
  - A request is flagged at accept if it is outside the range `[BASE_ADDR, BASE_ADDR + MEM_BYTES)`, or if start index plus beats exceeds `MEM_WORDS`.
  - A flagged request goes to ERR, ignoring `WAIT_CYCLES`.
  - `wbd_err_o` pulses 1 cycle after accept with `ack` and `lack` at 0, then the state moves to DONE.
  - The memory is not accessed.
- `WB_SLAVE_ERR_EN` undefined:
  - No range check; addresses wrap modulo `MEM_BYTES`.
  - `wbd_err_o` is constant 0 and the ERR state is not built.

## Test plan
- Single write/read, `WAIT_CYCLES=0`: write 32'hDEADBEEF to 0x100 with sel 4'hF, then read 0x100. Expect ack 2 cycles after stb, `lack=1` on that beat, and read data 32'hDEADBEEF.
- Byte lanes: write 32'h11223344 with sel 4'b0101 over existing 32'hAABBCCDD. Read back 32'hAA22CC44.
- Burst: write 4 beats starting at 0x200 with `bl=4`, data 1..4; read back a 4-beat burst with `bry` low on beat 2 for 2 cycles. Expect data 1,2,3,4, exactly 4 acks, `lack` only on the 4th, and no ack during the stall cycles.
- Wait states with `WAIT_CYCLES=3`: single read. Expect ack 5 cycles after stb. Drop `cyc` during WAIT on a second request: no ack, state IDLE next cycle.
- Wrap and reset: 2-beat read at the top word returns mem[MEM_WORDS-1] then mem[0]. Assert `rst_n=0` mid 8-beat burst: outputs 0 next cycle, no further acks, and earlier written data is still readable after reset.
- With `WB_SLAVE_ERR_EN` defined, access `BASE_ADDR + MEM_BYTES`. Expect `err_o=1` for one cycle 1 cycle after accept, `ack` never asserted, and memory unchanged.
